// File: rtl/multiplier_arbiter.sv
// rtl/multiplier_arbiter.sv - round-robin arbiter sharing one shift-add multiplier between two requesters
module multiplier_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 done0,
  output logic                 done1,
  output logic [2*WIDTH-1:0]   product,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic                 mul_ready,
  input  logic [2*WIDTH-1:0]   mul_product,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DELIVER   = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic       ptr;
  logic       owner;
  logic [1:0] tmo_cnt;
  logic       winner;
  logic       grant;
  logic       timeout;

  always_comb begin
    winner  = (req0 & req1) ? ptr : req1;
    grant   = (state == IDLE) & (req0 | req1) & mul_ready;
    // third WAIT_BUSY cycle with the multiplier never having gone busy
    timeout = (state == WAIT_BUSY) & mul_ready & (tmo_cnt == 2'd2);
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:      state_nxt = grant ? LAUNCH : IDLE;
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!mul_ready)   state_nxt = WAIT_DONE;
        else if (timeout) state_nxt = IDLE;
        else              state_nxt = WAIT_BUSY;
      end
      WAIT_DONE: state_nxt = mul_ready ? DELIVER : WAIT_DONE;
      DELIVER:   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Grant is visible in the cycle after capture, aligned with the new mul_a/mul_b
  always_comb begin
    gnt0      = (state == LAUNCH)  & ~owner;
    gnt1      = (state == LAUNCH)  &  owner;
    done0     = (state == DELIVER) & ~owner;
    done1     = (state == DELIVER) &  owner;
    mul_start = (state == LAUNCH);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      owner   <= 1'b0;
      tmo_cnt <= 2'd0;
      err     <= 1'b0;
      product <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner <= winner;
        ptr   <= ~winner;
        mul_a <= winner ? a1 : a0;
        mul_b <= winner ? b1 : b0;
      end
      if (state == WAIT_BUSY) tmo_cnt <= tmo_cnt + 2'd1;
      else                    tmo_cnt <= 2'd0;
      if (timeout) err <= 1'b1;
      // result is latched on entry to DELIVER so it is valid alongside done
      if ((state == WAIT_DONE) && mul_ready) product <= mul_product;
    end
  end

endmodule

// File: tb/tb_multiplier_arbiter.sv
// tb/tb_multiplier_arbiter.sv - self-checking bench for multiplier_arbiter
module tb_multiplier_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic gnt0, gnt1, done0, done1, mul_start, busy, err;
  logic [2*W-1:0] product;
  logic [2*W-1:0] mul_product = '0;
  logic [W-1:0] mul_a, mul_b;
  logic mul_ready = 1'b1;

  int total = 0;
  int bad = 0;

  bit mstuck = 1'b0;
  int lat_fixed = 3;
  int mcnt = 0;
  logic [W-1:0] ma = '0, mb = '0;

  always #5 clk = ~clk;

  multiplier_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .product(product), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_product(mul_product), .busy(busy), .err(err)
  );

  // Behavioural multiplier: drops ready after start, result after a latency
  always @(posedge clk) begin
    if (mstuck) begin
      mul_ready <= 1'b1;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mul_ready   <= 1'b1;
        mul_product <= {8'b0, ma} * {8'b0, mb};
      end
    end else if (mul_start) begin
      ma        <= mul_a;
      mb        <= mul_b;
      mul_ready <= 1'b0;
      mcnt      <= (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 5));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic run_until_done(output bit seen, output bit who, output logic [2*W-1:0] p);
    seen = 1'b0; who = 1'b0; p = '0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick;
      if (done0 | done1) begin
        seen = 1'b1; who = done1; p = product;
      end
    end
  endtask

  task automatic wait_gnt(output bit seen, output bit who);
    seen = 1'b0; who = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick;
      if (gnt0 | gnt1) begin
        seen = 1'b1; who = gnt1;
      end
    end
  endtask

  task automatic test_reset;
    apply_reset;
    rst = 1'b1;
    tick;
    total++; if ({gnt0, gnt1, done0, done1} !== 4'b0) begin bad++; $display("FAIL reset_pulses: got %b want 0000", {gnt0, gnt1, done0, done1}); end
    total++; if ({mul_start, busy, err} !== 3'b0) begin bad++; $display("FAIL reset_flags: got %b want 000", {mul_start, busy, err}); end
    total++; if (product !== 16'd0 || mul_a !== 8'd0 || mul_b !== 8'd0) begin bad++; $display("FAIL reset_data: got %0d/%0d/%0d want 0/0/0", product, mul_a, mul_b); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    bit seen, who; logic [2*W-1:0] p;
    req0 = 1'b1; a0 = 8'd13; b0 = 8'd11;
    tick;
    total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin bad++; $display("FAIL single_gnt: got %b%b want 10", gnt0, gnt1); end
    total++; if (mul_start !== 1'b1) begin bad++; $display("FAIL single_start: got %b want 1", mul_start); end
    req0 = 1'b0;
    tick;
    total++; if (mul_start !== 1'b0) begin bad++; $display("FAIL single_start_width: got %b want 0", mul_start); end
    run_until_done(seen, who, p);
    total++; if (!seen || who !== 1'b0 || p !== 16'd143) begin bad++; $display("FAIL single_done: got seen=%0d who=%0d p=%0d want 1/0/143", seen, who, p); end
    tick;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_tie;
    bit seen, who, gs, gw;
    logic [2*W-1:0] p;
    bit exp_w [3] = '{1'b0, 1'b1, 1'b0};
    apply_reset;
    req0 = 1'b1; req1 = 1'b1; a0 = 8'd3; b0 = 8'd5; a1 = 8'd7; b1 = 8'd9;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(gs, gw);
      total++; if (!gs || gw !== exp_w[k]) begin bad++; $display("FAIL tie_order%0d: got seen=%0d who=%0d want who=%0d", k, gs, gw, exp_w[k]); end
      if (k == 2) begin req0 = 1'b0; req1 = 1'b0; end
      run_until_done(seen, who, p);
      total++; if (!seen || who !== exp_w[k] || p !== (exp_w[k] ? 16'd63 : 16'd15)) begin bad++; $display("FAIL tie_done%0d: got seen=%0d who=%0d p=%0d", k, seen, who, p); end
    end
  endtask

  task automatic test_operand_stability;
    bit seen, who; logic [2*W-1:0] p;
    tick;
    req0 = 1'b1; a0 = 8'd4; b0 = 8'd4;
    tick;
    total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL stab_gnt: got %b want 1", gnt0); end
    a0 = 8'd200; req0 = 1'b0;
    tick;
    total++; if (mul_a !== 8'd4) begin bad++; $display("FAIL stab_mul_a: got %0d want 4", mul_a); end
    run_until_done(seen, who, p);
    total++; if (!seen || who !== 1'b0 || p !== 16'd16) begin bad++; $display("FAIL stab_done: got seen=%0d who=%0d p=%0d want 1/0/16", seen, who, p); end
  endtask

  task automatic test_early_drop;
    bit seen, who; logic [2*W-1:0] p;
    tick;
    req1 = 1'b1; a1 = 8'd255; b1 = 8'd255;
    tick;
    req1 = 1'b0;
    total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL drop_gnt: got %b want 1", gnt1); end
    run_until_done(seen, who, p);
    total++; if (!seen || who !== 1'b1 || p !== 16'd65025) begin bad++; $display("FAIL drop_done: got seen=%0d who=%0d p=%0d want 1/1/65025", seen, who, p); end
  endtask

  task automatic test_stuck;
    bit seen, who, any_done; logic [2*W-1:0] p;
    tick;
    mstuck = 1'b1;
    req0 = 1'b1; a0 = 8'd6; b0 = 8'd7;
    tick;
    req0 = 1'b0;
    total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL stuck_gnt: got %b want 1", gnt0); end
    any_done = 1'b0;
    for (int i = 0; i < 3; i++) begin tick; any_done |= (done0 | done1); end
    total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL stuck_early: got err=%b busy=%b want 0/1", err, busy); end
    tick; any_done |= (done0 | done1);
    total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL stuck_timeout: got err=%b busy=%b want 1/0", err, busy); end
    for (int i = 0; i < 5; i++) begin tick; any_done |= (done0 | done1); end
    total++; if (any_done) begin bad++; $display("FAIL stuck_nodone: got 1 want 0"); end
    mstuck = 1'b0;
    req1 = 1'b1; a1 = 8'd10; b1 = 8'd12;
    tick;
    req1 = 1'b0;
    total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL stuck_next_gnt: got %b want 1", gnt1); end
    run_until_done(seen, who, p);
    total++; if (!seen || who !== 1'b1 || p !== 16'd120) begin bad++; $display("FAIL stuck_next_done: got seen=%0d who=%0d p=%0d want 1/1/120", seen, who, p); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL stuck_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_mid;
    bit seen, who, gs, gw, any_done; logic [2*W-1:0] p;
    tick;
    lat_fixed = 10;
    req0 = 1'b1; a0 = 8'd9; b0 = 8'd9;
    tick;
    req0 = 1'b0;
    tick; tick;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++; if (busy !== 1'b0 || product !== 16'd0 || err !== 1'b0) begin bad++; $display("FAIL mid_reset: got busy=%b product=%0d err=%b want 0/0/0", busy, product, err); end
    any_done = 1'b0;
    for (int i = 0; i < 20; i++) begin tick; any_done |= (done0 | done1); end
    total++; if (any_done) begin bad++; $display("FAIL mid_nodone: got 1 want 0"); end
    lat_fixed = 3;
    req0 = 1'b1; req1 = 1'b1; a0 = 8'd2; b0 = 8'd3; a1 = 8'd5; b1 = 8'd5;
    wait_gnt(gs, gw);
    req0 = 1'b0; req1 = 1'b0;
    total++; if (!gs || gw !== 1'b0) begin bad++; $display("FAIL mid_ptr: got seen=%0d who=%0d want who=0", gs, gw); end
    run_until_done(seen, who, p);
    total++; if (!seen || who !== 1'b0 || p !== 16'd6) begin bad++; $display("FAIL mid_after: got seen=%0d who=%0d p=%0d want 1/0/6", seen, who, p); end
  endtask

  // Scoreboard: fair arbitration from driven requests, one op in flight, product = a*b
  task automatic test_random;
    bit mptr, pending, pend_who, g, exp_w;
    logic [2*W-1:0] pend_prod, last_prod;
    logic pr0, pr1;
    logic [W-1:0] pa0, pb0, pa1, pb1;
    apply_reset;
    lat_fixed = 0;
    mptr = 1'b0; pending = 1'b0; pend_who = 1'b0; pend_prod = '0; last_prod = '0;
    for (int c = 0; c < 600; c++) begin
      req0 = ($urandom_range(0, 3) != 0); req1 = ($urandom_range(0, 2) != 0);
      a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
      if (c >= 580) begin req0 = 1'b0; req1 = 1'b0; end
      pr0 = req0; pr1 = req1; pa0 = a0; pb0 = b0; pa1 = a1; pb1 = b1;
      tick;
      total++; if ((gnt0 & gnt1) | (done0 & done1) | ((gnt0 | gnt1) & (done0 | done1))) begin bad++; $display("FAIL rnd_exclusive c=%0d: got gnt=%b%b done=%b%b", c, gnt0, gnt1, done0, done1); end
      if (gnt0 | gnt1) begin
        g = gnt1;
        exp_w = (pr0 & pr1) ? mptr : pr1;
        total++; if (!(pr0 | pr1) || g !== exp_w) begin bad++; $display("FAIL rnd_winner c=%0d: got %0d want %0d", c, g, exp_w); end
        total++; if (pending) begin bad++; $display("FAIL rnd_regrant c=%0d: got grant while busy want none", c); end
        total++; if (mul_a !== (g ? pa1 : pa0) || mul_b !== (g ? pb1 : pb0)) begin bad++; $display("FAIL rnd_operands c=%0d: got %0d,%0d", c, mul_a, mul_b); end
        pending = 1'b1; pend_who = g;
        pend_prod = g ? ({8'b0, pa1} * {8'b0, pb1}) : ({8'b0, pa0} * {8'b0, pb0});
        mptr = ~g;
      end
      if (done0 | done1) begin
        total++; if (!pending || done1 !== pend_who || product !== pend_prod) begin bad++; $display("FAIL rnd_done c=%0d: got who=%0d p=%0d want who=%0d p=%0d", c, done1, product, pend_who, pend_prod); end
        pending = 1'b0;
        last_prod = product;
      end else begin
        total++; if (product !== last_prod) begin bad++; $display("FAIL rnd_hold c=%0d: got %0d want %0d", c, product, last_prod); end
      end
    end
    total++; if (pending) begin bad++; $display("FAIL rnd_drain: got pending op want none"); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_tie;
    test_operand_stability;
    test_early_drop;
    test_stuck;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
